// File: rtl/pll_fracdiv_pkg.sv
// rtl/pll_fracdiv_pkg.sv - shared types and defaults for the fractional clock-enable generator
package pll_fracdiv_pkg;

   localparam int CH_IDX_W        = 4;
   localparam int DEF_ACC_WIDTH   = 24;
   localparam int DEF_LOCK_CYCLES = 1024;

   typedef enum logic {
      LOCK_WAIT   = 1'b0,
      LOCK_LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/pll_fracdiv_chan.sv
// rtl/pll_fracdiv_chan.sv - one phase-accumulator channel with registered carry outputs
module pll_fracdiv_chan #(
   parameter int ACC_WIDTH = 24
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ACC_WIDTH-1:0] load_inc,
   input  logic [ACC_WIDTH-1:0] load_phase,
   output logic                 clk_en,
   output logic                 outclk
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] inc;
   logic [ACC_WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   // A load overrides whatever carry the running add would have produced this edge.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         inc    <= '0;
         clk_en <= 1'b0;
         outclk <= 1'b0;
      end else if (load) begin
         acc    <= load_phase;
         inc    <= load_inc;
         clk_en <= 1'b0;
         outclk <= 1'b0;
      end else begin
         acc    <= sum[ACC_WIDTH-1:0];
         clk_en <= sum[ACC_WIDTH];
         outclk <= outclk ^ sum[ACC_WIDTH];
      end
   end

endmodule

// File: rtl/pll_fracdiv.sv
// rtl/pll_fracdiv.sv - multi-channel fractional clock-enable generator with lock sequencing
module pll_fracdiv
   import pll_fracdiv_pkg::*;
#(
   parameter int NUM_CLOCKS  = 4,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [CH_IDX_W-1:0]   cfg_ch,
   input  logic [ACC_WIDTH-1:0]  cfg_inc,
   input  logic [ACC_WIDTH-1:0]  cfg_phase,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic                  locked
);

   localparam int                CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CH_IDX_W:0] NCH      = (CH_IDX_W + 1)'(NUM_CLOCKS);

   lock_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             wr_valid;

   // Writes to channels that do not exist are dropped and must not disturb lock timing.
   assign wr_valid = cfg_we && ({1'b0, cfg_ch} < NCH);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state <= LOCK_WAIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         LOCK_WAIT: begin
            if (wr_valid)
               cnt_nxt = '0;
            else if (cnt == CNT_LAST)
               state_nxt = LOCK_LOCKED;
            else
               cnt_nxt = cnt + 1'b1;
         end
         LOCK_LOCKED: begin
            if (wr_valid) begin
               state_nxt = LOCK_WAIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = LOCK_WAIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign locked = (state == LOCK_LOCKED);

   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
      pll_fracdiv_chan #(
         .ACC_WIDTH (ACC_WIDTH)
      ) u_chan (
         .refclk     (refclk),
         .rst        (rst),
         .load       (wr_valid && (cfg_ch == CH_IDX_W'(i))),
         .load_inc   (cfg_inc),
         .load_phase (cfg_phase),
         .clk_en     (clk_en[i]),
         .outclk     (outclk[i])
      );
   end

endmodule

// File: tb/tb_pll_fracdiv.sv
// tb/tb_pll_fracdiv.sv - self-checking bench for pll_fracdiv against a closed-form carry model
module tb_pll_fracdiv;

   localparam int NCLK = 4;
   localparam int ACCW = 24;
   localparam int LOCK = 16;

   logic            refclk;
   logic            rst;
   logic            cfg_we;
   logic [3:0]      cfg_ch;
   logic [ACCW-1:0] cfg_inc;
   logic [ACCW-1:0] cfg_phase;
   logic [NCLK-1:0] clk_en;
   logic [NCLK-1:0] outclk;
   logic            locked;

   pll_fracdiv #(
      .NUM_CLOCKS  (NCLK),
      .ACC_WIDTH   (ACCW),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .cfg_phase (cfg_phase),
      .clk_en    (clk_en),
      .outclk    (outclk),
      .locked    (locked)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   int checks = 0;
   int errors = 0;

   // Model: after n adds from preload p with increment k, the channel has wrapped
   // floor((p + n*k) / 2^ACCW) times; enable = that count just changed, outclk = its parity.
   longint unsigned m_inc [NCLK];
   longint unsigned m_ph  [NCLK];
   longint unsigned m_n   [NCLK];
   int              since;

   function automatic longint unsigned wraps(int c, longint unsigned n);
      return (m_ph[c] + n * m_inc[c]) >> ACCW;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCLK; c++) begin
         m_inc[c] = 0;
         m_ph[c]  = 0;
         m_n[c]   = 0;
      end
      since = 0;
   endtask

   task automatic model_edge();
      bit valid;
      valid = cfg_we && (cfg_ch < NCLK);
      for (int c = 0; c < NCLK; c++) begin
         if (valid && cfg_ch == c) begin
            m_inc[c] = cfg_inc;
            m_ph[c]  = cfg_phase;
            m_n[c]   = 0;
         end else begin
            m_n[c]++;
         end
      end
      if (valid)              since = 0;
      else if (since < 100000) since++;
   endtask

   task automatic tick();
      logic [NCLK-1:0] e_en, e_out;
      @(posedge refclk);
      model_edge();
      #1;
      for (int c = 0; c < NCLK; c++) begin
         e_en[c]  = (m_n[c] > 0) && (wraps(c, m_n[c]) != wraps(c, m_n[c] - 1));
         e_out[c] = wraps(c, m_n[c]) & 1;
      end
      chk("clk_en", 32'(clk_en), 32'(e_en));
      chk("outclk", 32'(outclk), 32'(e_out));
      chk("locked", 32'(locked), 32'(since >= LOCK));
   endtask

   task automatic do_write(int ch, logic [ACCW-1:0] inc, logic [ACCW-1:0] ph);
      cfg_we    = 1'b1;
      cfg_ch    = 4'(ch);
      cfg_inc   = inc;
      cfg_phase = ph;
      tick();
      cfg_we    = 1'b0;
   endtask

   typedef struct {
      int              ch;
      logic [ACCW-1:0] inc;
      logic [ACCW-1:0] ph;
      int              cycles;
      int              exp_carries;
      logic            exp_out;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int cnt;
      bit found;

      tbl[0] = '{0, 24'h400000, 24'h000000, 16, 4, 1'b0};
      tbl[1] = '{1, 24'h555555, 24'h000003,  9, 3, 1'b1};
      tbl[2] = '{2, 24'h000001, 24'hFFFFFF,  1, 1, 1'b1};
      tbl[3] = '{3, 24'h800000, 24'h000000,  7, 3, 1'b1};
      tbl[4] = '{3, 24'hFFFFFF, 24'h000000,  5, 4, 1'b0};
      tbl[5] = '{0, 24'h000000, 24'h123456, 10, 0, 1'b0};

      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
      model_reset();
      repeat (3) @(posedge refclk);
      #1;
      chk("reset_clk_en", 32'(clk_en), 0);
      chk("reset_locked", 32'(locked), 0);
      rst = 1'b0;

      // Lock after exactly LOCK edges with no writes.
      repeat (LOCK - 1) tick();
      chk("lock_edge15", 32'(locked), 0);
      tick();
      chk("lock_edge16", 32'(locked), 1);
      chk("idle_outclk", 32'(outclk), 0);

      // ch0 quarter rate: pulse on the 4th edge, locked drops on the write edge.
      do_write(0, 24'h400000, 24'h000000);
      chk("wr_unlock", 32'(locked), 0);
      cnt = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (clk_en[0]) cnt = k;
      end
      chk("ch0_first_pulse_edge", 32'(cnt), 4);
      repeat (LOCK - 5) tick();
      chk("relock_edge15", 32'(locked), 0);
      tick();
      chk("relock_edge16", 32'(locked), 1);

      for (int v = 0; v < 6; v++) begin
         do_write(tbl[v].ch, tbl[v].inc, tbl[v].ph);
         cnt = 0;
         for (int k = 0; k < tbl[v].cycles; k++) begin
            tick();
            if (clk_en[tbl[v].ch]) cnt++;
         end
         chk($sformatf("tbl%0d_carries", v), 32'(cnt), 32'(tbl[v].exp_carries));
         chk($sformatf("tbl%0d_outclk", v), 32'(outclk[tbl[v].ch]), 32'(tbl[v].exp_out));
      end

      // Long run: no drift on a non-power-of-two increment.
      do_write(0, 24'h400000, 24'h000000);
      do_write(1, 24'h555555, 24'h000000);
      cnt = 0;
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (clk_en[1]) cnt++;
      end
      chk("ch1_drift", 32'(cnt), 32'((64'd3000 * 64'h555555) >> ACCW));

      // ch2 preloaded one below wrap; ch0 keeps its cadence (model checks every tick).
      do_write(2, 24'h000001, 24'hFFFFFF);
      chk("ch2_load_quiet", 32'(clk_en[2]), 0);
      tick();
      chk("ch2_first_pulse", 32'(clk_en[2]), 1);
      repeat (LOCK + 2) tick();

      // Invalid channel index: nothing changes, lock holds.
      chk("pre_ch7_locked", 32'(locked), 1);
      do_write(7, 24'h123456, 24'hABCDEF);
      chk("ch7_locked", 32'(locked), 1);

      // Write landing on a carry edge of ch0 wins; new phase takes effect.
      do_write(0, 24'h400000, 24'h000000);
      repeat (3) tick();
      do_write(0, 24'h400000, 24'hC00000);
      chk("collide_clk_en", 32'(clk_en[0]), 0);
      chk("collide_outclk", 32'(outclk[0]), 0);
      tick();
      chk("collide_phase_pulse", 32'(clk_en[0]), 1);

      // Randomised writes, including invalid channels and idle increments.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            logic [ACCW-1:0] ri;
            case ($urandom_range(0, 3))
               0:       ri = '0;
               1:       ri = 24'h800000 | 24'($urandom_range(0, 255));
               2:       ri = 24'hFFFFFF;
               default: ri = 24'($urandom);
            endcase
            do_write(int'($urandom_range(0, 7)), ri, 24'($urandom));
         end else begin
            tick();
         end
      end

      // Async reset while outclk[3] is high clears everything before the next edge.
      do_write(3, 24'h800000, 24'h000000);
      found = 0;
      for (int k = 0; k < 64 && !found; k++) begin
         tick();
         if (outclk[3]) found = 1;
      end
      chk("outclk3_seen", 32'(found), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_clk_en", 32'(clk_en), 0);
      chk("async_outclk", 32'(outclk), 0);
      chk("async_locked", 32'(locked), 0);
      model_reset();
      @(posedge refclk);
      #1 rst = 1'b0;
      repeat (LOCK + 4) tick();
      chk("post_reset_locked", 32'(locked), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
